ctrl_layer_seq: RTL and testbench

Layer sequencer that drives the programmable convolution-volume counter (the done_ac3/last_fil generator) and consumes its outputs. It holds a small per-layer table of volume counts and walks through the layers. For each layer it loads and clears the counter, waits for the layer-done indication, and performs a write-back handshake before moving to the next layer. It sits directly downstream of that counter and reports completion to the top-level controller.

---
 rtl/ctrl_layer_seq_if.sv | 43 ++++
 rtl/ctrl_layer_seq.sv | 144 ++++++++++++++
 tb/tb_ctrl_layer_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_layer_seq_if.sv
// Bundles the config bus, run control, counter hookup and write-back handshake
// of the layer sequencer. The slave modport is the sequencer's view of it.
interface ctrl_layer_seq_if #(
    parameter int MNO = 288,
    parameter int NL  = 8
);
    localparam int MW = $clog2(MNO);
    localparam int AW = $clog2(NL);
    localparam int LW = AW + 1;

    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [MW-1:0] cfg_data;
    logic [LW-1:0] num_layers;
    logic          start;
    logic          abort;
    logic          done_ac3;
    logic          last_fil;
    logic          wb_ack;
    logic          cnt_load;
    logic          cnt_clear;
    logic [MW-1:0] max_val;
    logic [AW-1:0] layer_idx;
    logic          layer_start;
    logic          wb_req;
    logic          busy;
    logic          all_done;
    logic          seq_err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, num_layers, start, abort,
               done_ac3, last_fil, wb_ack,
        input  cnt_load, cnt_clear, max_val, layer_idx, layer_start,
               wb_req, busy, all_done, seq_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, num_layers, start, abort,
               done_ac3, last_fil, wb_ack,
        output cnt_load, cnt_clear, max_val, layer_idx, layer_start,
               wb_req, busy, all_done, seq_err
    );
endinterface

// File: rtl/ctrl_layer_seq.sv
// Layer sequencer: walks a per-layer table of volume counts, programs the
// volume counter for each layer and handshakes the write-back between layers.
module ctrl_layer_seq #(
    parameter int MNO = 288,
    parameter int NL  = 8
) (
    input  logic             clk,
    input  logic             rst,
    ctrl_layer_seq_if.slave  bus
);
    // state  | meaning
    // IDLE   | waiting for start; table writable
    // LOAD   | max_val <= table[layer_idx], cnt_load pulse
    // CLEAR  | cnt_clear + layer_start pulse, last_seen cleared
    // RUN    | counter running, waiting for done_ac3
    // WB     | wb_req held until wb_ack
    // NEXT   | advance layer or finish
    // FIN    | all_done pulse

    localparam int MW = $clog2(MNO);
    localparam int AW = $clog2(NL);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_WB,
        S_NEXT,
        S_FIN
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] layer_idx, layer_idx_nxt;
    logic [MW-1:0] max_val, max_val_nxt;
    logic [LW-1:0] nl_lat, nl_lat_nxt;
    logic          last_seen, last_seen_nxt;
    logic          seq_err, seq_err_nxt;
    logic          clr_pend, clr_pend_nxt;
    logic [MW-1:0] tbl [NL];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            layer_idx <= '0;
            max_val   <= '0;
            nl_lat    <= '0;
            last_seen <= 1'b0;
            seq_err   <= 1'b0;
            clr_pend  <= 1'b0;
        end else begin
            state     <= state_nxt;
            layer_idx <= layer_idx_nxt;
            max_val   <= max_val_nxt;
            nl_lat    <= nl_lat_nxt;
            last_seen <= last_seen_nxt;
            seq_err   <= seq_err_nxt;
            clr_pend  <= clr_pend_nxt;
        end
    end

    // Table is writable only while idle so a running layer never sees a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NL; i++) tbl[i] <= '0;
        end else if (bus.cfg_we && state == S_IDLE) begin
            tbl[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_comb begin
        state_nxt     = state;
        layer_idx_nxt = layer_idx;
        max_val_nxt   = max_val;
        nl_lat_nxt    = nl_lat;
        last_seen_nxt = last_seen;
        seq_err_nxt   = seq_err;
        clr_pend_nxt  = 1'b0;

        if (bus.abort && state != S_IDLE) begin
            state_nxt    = S_IDLE;
            clr_pend_nxt = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.num_layers == '0) begin
                            seq_err_nxt = 1'b0;
                            state_nxt   = S_FIN;
                        end else if (bus.num_layers > LW'(NL)) begin
                            seq_err_nxt = 1'b1;
                        end else begin
                            seq_err_nxt   = 1'b0;
                            nl_lat_nxt    = bus.num_layers;
                            layer_idx_nxt = '0;
                            state_nxt     = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    max_val_nxt = tbl[layer_idx];
                    state_nxt   = S_CLEAR;
                end
                S_CLEAR: begin
                    last_seen_nxt = 1'b0;
                    state_nxt     = S_RUN;
                end
                S_RUN: begin
                    if (bus.last_fil) last_seen_nxt = 1'b1;
                    if (bus.done_ac3) begin
                        // done without a preceding last_fil means the counter skipped a step
                        if (bus.last_fil || (!last_seen && max_val >= MW'(2)))
                            seq_err_nxt = 1'b1;
                        state_nxt = S_WB;
                    end
                end
                S_WB: begin
                    if (bus.wb_ack) state_nxt = S_NEXT;
                end
                S_NEXT: begin
                    if ({1'b0, layer_idx} == nl_lat - LW'(1)) begin
                        state_nxt = S_FIN;
                    end else begin
                        layer_idx_nxt = layer_idx + AW'(1);
                        state_nxt     = S_LOAD;
                    end
                end
                S_FIN: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.cnt_load    = (state == S_LOAD);
    assign bus.cnt_clear   = (state == S_CLEAR) || clr_pend;
    assign bus.layer_start = (state == S_CLEAR);
    assign bus.wb_req      = (state == S_WB);
    assign bus.busy        = (state != S_IDLE);
    assign bus.all_done    = (state == S_FIN);
    assign bus.max_val     = max_val;
    assign bus.layer_idx   = layer_idx;
    assign bus.seq_err     = seq_err;
endmodule

// File: tb/tb_ctrl_layer_seq.sv
// Directed bench for the layer sequencer; expected max_val per layer is queued
// when a run is programmed and popped at each layer_start.
module tb_ctrl_layer_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;
    int   n_load = 0;
    int   n_clear = 0;
    int   n_lstart = 0;
    int   base_done, base_load, base_clear, base_lstart;
    int   exp_q[$];

    ctrl_layer_seq_if #(.MNO(288), .NL(8)) bus ();

    ctrl_layer_seq #(.MNO(288), .NL(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.all_done)    n_done   <= n_done + 1;
            if (bus.cnt_load)    n_load   <= n_load + 1;
            if (bus.cnt_clear)   n_clear  <= n_clear + 1;
            if (bus.layer_start) n_lstart <= n_lstart + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        base_done   = n_done;
        base_load   = n_load;
        base_clear  = n_clear;
        base_lstart = n_lstart;
    endtask

    task automatic cfg_write(input int addr, input int data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'(addr);
        bus.cfg_data = 9'(data);
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic start_run(input int n);
        bus.num_layers = 4'(n);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    // Called at the LOAD sample point; leaves the DUT in RUN.
    task automatic enter_layer(input int idx);
        int exp_mv;
        chk("cnt_load", bus.cnt_load, 1);
        tick();
        chk("cnt_clear_layer", bus.cnt_clear, 1);
        chk("layer_start", bus.layer_start, 1);
        chk("layer_idx", bus.layer_idx, idx);
        if (exp_q.size() == 0) begin
            exp_mv = -1;
        end else begin
            exp_mv = exp_q.pop_front();
        end
        chk("max_val", bus.max_val, exp_mv);
        tick();
        chk("run_no_wb_req", bus.wb_req, 0);
    endtask

    // Called in RUN; leaves the DUT in NEXT.
    task automatic finish_layer(input bit with_last, input int ack_wait);
        if (with_last) begin
            bus.last_fil = 1'b1;
            tick();
            bus.last_fil = 1'b0;
        end
        bus.done_ac3 = 1'b1;
        tick();
        bus.done_ac3 = 1'b0;
        chk("wb_req_rise", bus.wb_req, 1);
        for (int k = 0; k < ack_wait; k++) begin
            tick();
            chk("wb_req_hold", bus.wb_req, 1);
        end
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        chk("wb_req_drop", bus.wb_req, 0);
        chk("busy_in_next", bus.busy, 1);
    endtask

    initial begin
        int n;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.num_layers = '0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.done_ac3 = 1'b0; bus.last_fil = 1'b0; bus.wb_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_busy", bus.busy, 0);
        chk("rst_max_val", bus.max_val, 0);
        chk("rst_layer_idx", bus.layer_idx, 0);
        chk("rst_seq_err", bus.seq_err, 0);
        chk("rst_pulses", {bus.cnt_load, bus.cnt_clear, bus.layer_start, bus.wb_req, bus.all_done}, 0);

        // two-layer run {3,5}
        cfg_write(0, 3);
        cfg_write(1, 5);
        snap();
        exp_q.push_back(3);
        exp_q.push_back(5);
        start_run(2);
        chk("t1_busy", bus.busy, 1);
        for (int i = 0; i < 2; i++) begin
            enter_layer(i);
            finish_layer(1'b1, 1);
            tick();
            if (i == 0) chk("t1_load2_idx", bus.layer_idx, 1);
        end
        chk("t1_all_done", bus.all_done, 1);
        chk("t1_fin_busy", bus.busy, 1);
        tick();
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_done_gone", bus.all_done, 0);
        chk("t1_max_val_held", bus.max_val, 5);
        chk("t1_seq_err", bus.seq_err, 0);
        chk("t1_done_count", n_done - base_done, 1);
        chk("t1_lstart_count", n_lstart - base_lstart, 2);

        // zero layers: straight to FIN
        snap();
        start_run(0);
        n = 0;
        while (!bus.all_done && n < 4) begin
            tick();
            n++;
        end
        chk("t2_all_done", bus.all_done, 1);
        tick();
        chk("t2_busy", bus.busy, 0);
        chk("t2_no_load", n_load - base_load, 0);
        chk("t2_no_clear", n_clear - base_clear, 0);

        // abort in RUN of layer 0
        snap();
        exp_q.push_back(3);
        start_run(1);
        enter_layer(0);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t3_busy", bus.busy, 0);
        chk("t3_abort_clear", bus.cnt_clear, 1);
        chk("t3_max_val_kept", bus.max_val, 3);
        tick();
        chk("t3_clear_one_cycle", bus.cnt_clear, 0);
        chk("t3_no_done", n_done - base_done, 0);

        // done_ac3 without last_fil, max_val=4
        cfg_write(0, 4);
        exp_q.push_back(4);
        start_run(1);
        enter_layer(0);
        finish_layer(1'b0, 0);
        chk("t4_err_set", bus.seq_err, 1);
        tick();
        chk("t4_fin_done", bus.all_done, 1);
        chk("t4_err_fin", bus.seq_err, 1);
        tick();
        chk("t4_err_idle", bus.seq_err, 1);
        start_run(1);
        chk("t4_err_cleared", bus.seq_err, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        start_run(9);
        chk("t4_over_busy", bus.busy, 0);
        chk("t4_over_err", bus.seq_err, 1);

        // write while busy is dropped
        exp_q.push_back(4);
        start_run(1);
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 9'd7;
        chk("cnt_load", bus.cnt_load, 1);
        tick();
        bus.cfg_we = 1'b0;
        chk("t5_max_val_busy", bus.max_val, exp_q.pop_front());
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp_q.push_back(4);
        start_run(1);
        enter_layer(0);

        // long write-back wait, then rst mid-WB
        finish_layer(1'b1, 10);
        tick();
        chk("t6_fin", bus.all_done, 1);
        tick();
        exp_q.push_back(4);
        start_run(1);
        enter_layer(0);
        bus.done_ac3 = 1'b1;
        tick();
        bus.done_ac3 = 1'b0;
        chk("t6_in_wb", bus.wb_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_outputs", {bus.cnt_load, bus.cnt_clear, bus.layer_start, bus.wb_req,
                               bus.busy, bus.all_done, bus.seq_err}, 0);
        chk("t6_rst_max_val", bus.max_val, 0);
        chk("t6_rst_layer_idx", bus.layer_idx, 0);

        // table was cleared by reset: zero entry never completes
        exp_q.push_back(0);
        start_run(1);
        enter_layer(0);
        for (int k = 0; k < 5; k++) tick();
        chk("t7_stuck_run", {bus.busy, bus.wb_req}, 2'b10);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t7_abort_idle", bus.busy, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
